// File: rtl/idma_sync_256b_noc_req_pkg.sv
// Shared NoC flit layout and engine state encoding for the iDMA requester
// and its responder.
package idma_noc_pkg;

  // Header flit field positions
  localparam int RW_POS         = 0;
  localparam int COOR_START_POS = 2;
  localparam int BASE_START_POS = 56;
  localparam int LEN_START_POS  = 72;

  // Read configuration acknowledge bit (first config flit)
  localparam int CFG_ACK_POS = 0;

  // Write response bits
  localparam int         RESP_START_POS = 0;
  localparam int         RESP_WIDTH     = 2;
  localparam logic [1:0] RESP_OK        = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_CFG1,
    RD_CFG2,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  // A write response is good only with both response bits set and last=1.
  function automatic logic resp_ok(input logic [RESP_WIDTH-1:0] resp,
                                   input logic                  last);
    return (resp == RESP_OK) && last;
  endfunction

endpackage

// File: rtl/idma_sync_256b_noc_req_if.sv
// Command, write-source, read-sink, NoC and status signals of the
// iDMA NoC requester, bundled as one interface.
interface idma_sync_256b_noc_req_if #(
  parameter int DATA_WIDTH = 256,
  parameter int COOR_WIDTH = 4,
  parameter int BASE_WIDTH = 16,
  parameter int LEN_WIDTH  = 20
);

  // Command
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_rw;
  logic [COOR_WIDTH-1:0] cmd_coor;
  logic [BASE_WIDTH-1:0] cmd_offset;
  logic [LEN_WIDTH-1:0]  cmd_len;

  // Write data source
  logic                  wsrc_valid;
  logic [DATA_WIDTH-1:0] wsrc_data;
  logic                  wsrc_ready;

  // Read data sink
  logic                  rsink_valid;
  logic [DATA_WIDTH-1:0] rsink_data;
  logic                  rsink_last;
  logic                  rsink_ready;

  // NoC send / receive
  logic                  send_valid;
  logic [DATA_WIDTH-1:0] send_flit;
  logic                  send_last;
  logic                  send_ready;
  logic                  recv_valid;
  logic [DATA_WIDTH-1:0] recv_flit;
  logic                  recv_last;
  logic                  recv_ready;

  // Status
  logic                  busy;
  logic                  done;
  logic                  err;

  // Engine side
  modport master (
    input  cmd_valid, cmd_rw, cmd_coor, cmd_offset, cmd_len,
    output cmd_ready,
    input  wsrc_valid, wsrc_data,
    output wsrc_ready,
    output rsink_valid, rsink_data, rsink_last,
    input  rsink_ready,
    output send_valid, send_flit, send_last,
    input  send_ready,
    input  recv_valid, recv_flit, recv_last,
    output recv_ready,
    output busy, done, err
  );

  // Environment side (command issuer, data endpoints, NoC)
  modport slave (
    output cmd_valid, cmd_rw, cmd_coor, cmd_offset, cmd_len,
    input  cmd_ready,
    output wsrc_valid, wsrc_data,
    input  wsrc_ready,
    input  rsink_valid, rsink_data, rsink_last,
    output rsink_ready,
    input  send_valid, send_flit, send_last,
    output send_ready,
    output recv_valid, recv_flit, recv_last,
    input  recv_ready,
    input  busy, done, err
  );

endinterface

// File: rtl/idma_sync_256b_noc_req_fwd_pipe.sv
// One-deep forward register slice: registers data and valid, keeps the
// output stable under backpressure and accepts a new word in the same cycle
// the held word drains.
module fwd_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  // Occupancy: fill on input handshake, empty when the held word drains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Payload capture; held unchanged while stalled.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_reg <= in_data;
    end
  end

endmodule

// File: rtl/idma_sync_256b_noc_req.sv
// iDMA NoC requester: turns a read/write command into a header flit plus
// write data on the NoC send port, and collects config/data/response flits
// from the NoC receive port.
module idma_sync_256b_noc_req
  import idma_noc_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int COOR_WIDTH = 4,
  parameter int BASE_WIDTH = 16,
  parameter int LEN_WIDTH  = 20
) (
  input logic                      clk,
  input logic                      rst_n,
  idma_sync_256b_noc_req_if.master bus
);

  state_t               state_reg, state_next;
  logic                 rw_reg, rw_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 done_reg, done_next;
  logic                 err_reg, err_next;

  logic                  cmd_ready;
  logic                  cnt_is_last;
  logic [DATA_WIDTH-1:0] hdr_flit;

  logic                  st_in_valid;
  logic [DATA_WIDTH:0]   st_in_data;
  logic                  st_in_ready;
  logic                  st_out_valid;
  logic [DATA_WIDTH:0]   st_out_data;

  logic wsrc_ready;
  logic recv_ready;
  logic rsink_valid;
  logic rsink_last;

  // Count wraps naturally; len-1 is the index of the final flit.
  assign cnt_is_last = (cnt_reg == (len_reg - LEN_WIDTH'(1)));

  // The header is pushed into the send stage in the accept cycle so it is
  // on the NoC one cycle later; the stage must be free to take it.
  assign cmd_ready = (state_reg == IDLE) && st_in_ready;

  // Header flit assembled directly from the command fields.
  always_comb begin
    hdr_flit                                    = '0;
    hdr_flit[RW_POS]                            = bus.cmd_rw;
    hdr_flit[COOR_START_POS +: COOR_WIDTH]      = bus.cmd_coor;
    hdr_flit[BASE_START_POS +: BASE_WIDTH]      = bus.cmd_offset;
    hdr_flit[LEN_START_POS  +: LEN_WIDTH]       = bus.cmd_len;
  end

  // Next-state, counters, stage input and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    rw_next     = rw_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    st_in_valid = 1'b0;
    st_in_data  = {1'b0, bus.wsrc_data};
    wsrc_ready  = 1'b0;
    recv_ready  = 1'b0;
    rsink_valid = 1'b0;
    rsink_last  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          rw_next  = bus.cmd_rw;
          len_next = bus.cmd_len;
          cnt_next = '0;
          if (bus.cmd_len == '0) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else begin
            // Reads end the packet at the header, writes continue with data.
            st_in_valid = 1'b1;
            st_in_data  = {~bus.cmd_rw, hdr_flit};
            state_next  = HDR;
          end
        end
      end

      HDR: begin
        if (st_out_valid && bus.send_ready) begin
          state_next = rw_reg ? WR_DATA : RD_CFG1;
        end
      end

      RD_CFG1: begin
        recv_ready = 1'b1;
        if (bus.recv_valid) begin
          err_next   = !bus.recv_flit[CFG_ACK_POS];
          state_next = RD_CFG2;
        end
      end

      RD_CFG2: begin
        recv_ready = 1'b1;
        if (bus.recv_valid) begin
          state_next = RD_DATA;
        end
      end

      RD_DATA: begin
        rsink_valid = bus.recv_valid;
        recv_ready  = bus.rsink_ready;
        rsink_last  = cnt_is_last;
        if (bus.recv_valid && bus.rsink_ready) begin
          cnt_next = cnt_reg + LEN_WIDTH'(1);
          err_next = (bus.recv_last != cnt_is_last);
          if (cnt_is_last) begin
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end

      WR_DATA: begin
        st_in_valid = bus.wsrc_valid;
        st_in_data  = {cnt_is_last, bus.wsrc_data};
        wsrc_ready  = st_in_ready;
        if (bus.wsrc_valid && st_in_ready) begin
          cnt_next = cnt_reg + LEN_WIDTH'(1);
          if (cnt_is_last) begin
            cnt_next   = '0;
            state_next = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        recv_ready = 1'b1;
        if (bus.recv_valid) begin
          done_next  = 1'b1;
          err_next   = !resp_ok(bus.recv_flit[RESP_START_POS +: RESP_WIDTH],
                                bus.recv_last);
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, latched command and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rw_reg    <= 1'b0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rw_reg    <= rw_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  fwd_pipe #(
    .DATA_W (DATA_WIDTH + 1)
  ) u_send_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (st_in_valid),
    .in_data   (st_in_data),
    .in_ready  (st_in_ready),
    .out_valid (st_out_valid),
    .out_data  (st_out_data),
    .out_ready (bus.send_ready)
  );

  assign bus.cmd_ready   = cmd_ready;
  assign bus.wsrc_ready  = wsrc_ready;
  assign bus.recv_ready  = recv_ready;
  assign bus.rsink_valid = rsink_valid;
  assign bus.rsink_data  = bus.recv_flit;
  assign bus.rsink_last  = rsink_last;
  assign bus.send_valid  = st_out_valid;
  assign bus.send_flit   = st_out_data[DATA_WIDTH-1:0];
  assign bus.send_last   = st_out_data[DATA_WIDTH];
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.err         = err_reg;

endmodule

// File: tb/tb_idma_sync_256b_noc_req.sv
// Directed bench for the iDMA NoC requester with send/rsink scoreboards.
module tb_idma_sync_256b_noc_req;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   toggle_mode = 1'b0;

  logic [256:0] q_send[$];
  logic [256:0] q_rsink[$];
  logic         stall_prev = 1'b0;
  logic [256:0] held = '0;

  idma_sync_256b_noc_req_if #(
    .DATA_WIDTH(256), .COOR_WIDTH(4), .BASE_WIDTH(16), .LEN_WIDTH(20)
  ) bus ();

  idma_sync_256b_noc_req #(
    .DATA_WIDTH(256), .COOR_WIDTH(4), .BASE_WIDTH(16), .LEN_WIDTH(20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic checkw(input string tag, input logic [256:0] obs, input logic [256:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mk_hdr(input logic rw, input logic [3:0] coor,
                                          input logic [15:0] off, input logic [19:0] len);
    logic [255:0] h;
    h = '0;
    h[0]     = rw;
    h[5:2]   = coor;
    h[71:56] = off;
    h[91:72] = len;
    return h;
  endfunction

  task automatic issue_cmd(input logic rw, input logic [3:0] coor,
                           input logic [15:0] off, input logic [19:0] len);
    bus.cmd_valid  = 1'b1;
    bus.cmd_rw     = rw;
    bus.cmd_coor   = coor;
    bus.cmd_offset = off;
    bus.cmd_len    = len;
    if (len != 20'd0) q_send.push_back({~rw, mk_hdr(rw, coor, off, len)});
    for (int i = 0; i < 200; i++) begin
      at_neg();
      if (bus.cmd_ready) break;
    end
    check1("cmd_ready", bus.cmd_ready, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_recv(input string tag);
    for (int i = 0; i < 200; i++) begin
      at_neg();
      if (bus.recv_ready) break;
    end
    check1(tag, bus.recv_ready, 1'b1);
    tick();
    bus.recv_valid = 1'b0;
    bus.recv_last  = 1'b0;
  endtask

  task automatic send_recv(input logic [255:0] flit, input logic last, input string tag);
    bus.recv_valid = 1'b1;
    bus.recv_flit  = flit;
    bus.recv_last  = last;
    wait_recv(tag);
  endtask

  task automatic push_wsrc(input logic [255:0] data, input logic last_exp);
    q_send.push_back({last_exp, data});
    bus.wsrc_valid = 1'b1;
    bus.wsrc_data  = data;
    for (int i = 0; i < 200; i++) begin
      at_neg();
      if (bus.wsrc_ready) break;
    end
    check1("wsrc_ready", bus.wsrc_ready, 1'b1);
    tick();
    bus.wsrc_valid = 1'b0;
  endtask

  task automatic read_xfer(input logic [3:0] coor, input logic [15:0] off,
                           input logic [19:0] len, input int early_idx, input int stall);
    logic [255:0] d;
    issue_cmd(1'b0, coor, off, len);
    d = rnd256();
    d[0] = 1'b1;
    bus.recv_valid = 1'b1;
    bus.recv_flit  = d;
    bus.recv_last  = 1'b0;
    at_neg();
    check1("hdr_timing", bus.send_valid, 1'b1);
    check1("busy_rd", bus.busy, 1'b1);
    check1("recv_hold_hdr", bus.recv_ready, 1'b0);
    wait_recv("cfg1");
    send_recv(rnd256(), 1'b0, "cfg2");
    for (int i = 0; i < int'(len); i++) begin
      d = rnd256();
      q_rsink.push_back({(i == int'(len) - 1), d});
      bus.recv_valid = 1'b1;
      bus.recv_flit  = d;
      bus.recv_last  = (i == early_idx) || (i == int'(len) - 1);
      if (i == 0 && stall > 0) begin
        bus.rsink_ready = 1'b0;
        repeat (stall) begin
          at_neg();
          check1("rsink_stall_valid", bus.rsink_valid, 1'b1);
          check1("recv_ready_stall", bus.recv_ready, 1'b0);
        end
        tick();
        bus.rsink_ready = 1'b1;
      end
      wait_recv("rd_beat");
      at_neg();
      check1("rd_err", bus.err, (i == early_idx));
      check1("rd_done", bus.done, (i == int'(len) - 1));
      tick();
    end
    at_neg();
    check1("rd_done_pulse", bus.done, 1'b0);
    check1("rd_cmd_ready", bus.cmd_ready, 1'b1);
    tick();
  endtask

  task automatic write_xfer(input logic [3:0] coor, input logic [15:0] off, input logic [19:0] len,
                            input logic [255:0] resp, input logic resp_last, input logic exp_err);
    issue_cmd(1'b1, coor, off, len);
    for (int i = 0; i < int'(len); i++) push_wsrc(rnd256(), (i == int'(len) - 1));
    send_recv(resp, resp_last, "wr_resp");
    at_neg();
    check1("wr_done", bus.done, 1'b1);
    check1("wr_err", bus.err, exp_err);
    at_neg();
    check1("wr_done_pulse", bus.done, 1'b0);
    tick();
  endtask

  // -------------------------------------------------------------- monitors
  // Send-side scoreboard: every NoC handshake must match the next expected flit.
  always @(negedge clk) begin
    logic [256:0] e;
    if (bus.send_valid && bus.send_ready) begin
      if (q_send.size() == 0) begin
        check1("send_extra", bus.send_valid, 1'b0);
      end else begin
        e = q_send.pop_front();
        checkw("send_flit", {bus.send_last, bus.send_flit}, e);
      end
    end
  end

  // Read-sink scoreboard.
  always @(negedge clk) begin
    logic [256:0] e;
    if (bus.rsink_valid && bus.rsink_ready) begin
      if (q_rsink.size() == 0) begin
        check1("rsink_extra", bus.rsink_valid, 1'b0);
      end else begin
        e = q_rsink.pop_front();
        checkw("rsink_beat", {bus.rsink_last, bus.rsink_data}, e);
      end
    end
  end

  // A stalled send flit must stay valid and unchanged in the next cycle.
  always @(negedge clk) begin
    if (stall_prev && rst_n) begin
      check1("send_stable_valid", bus.send_valid, 1'b1);
      checkw("send_stable_flit", {bus.send_last, bus.send_flit}, held);
    end
    stall_prev <= bus.send_valid && !bus.send_ready;
    held       <= {bus.send_last, bus.send_flit};
  end

  // NoC send-side ready: constant high or toggling every cycle.
  initial begin
    bus.send_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle_mode) bus.send_ready = ~bus.send_ready;
      else             bus.send_ready = 1'b1;
    end
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [255:0] d;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_rw     = 1'b0;
    bus.cmd_coor   = '0;
    bus.cmd_offset = '0;
    bus.cmd_len    = '0;
    bus.wsrc_valid = 1'b0;
    bus.wsrc_data  = '0;
    bus.rsink_ready = 1'b1;
    bus.recv_valid = 1'b0;
    bus.recv_flit  = '0;
    bus.recv_last  = 1'b0;

    // Reset values
    repeat (3) tick();
    rst_n = 1'b1;
    at_neg();
    check1("rst_send_valid", bus.send_valid, 1'b0);
    check1("rst_rsink_valid", bus.rsink_valid, 1'b0);
    check1("rst_wsrc_ready", bus.wsrc_ready, 1'b0);
    check1("rst_recv_ready", bus.recv_ready, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_done", bus.done, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    tick();

    // Basic read: coor=3, offset=0x40, len=4
    read_xfer(4'd3, 16'h0040, 20'd4, -1, 0);

    // Basic write: len=3, good response 0x3 with last
    write_xfer(4'd5, 16'h1234, 20'd3, 256'h3, 1'b1, 1'b0);

    // Zero-length command
    issue_cmd(1'b0, 4'd1, 16'h0002, 20'd0);
    at_neg();
    check1("len0_done", bus.done, 1'b1);
    check1("len0_err", bus.err, 1'b1);
    check1("len0_send_valid", bus.send_valid, 1'b0);
    check1("len0_cmd_ready", bus.cmd_ready, 1'b1);
    at_neg();
    check1("len0_done_pulse", bus.done, 1'b0);
    check1("len0_err_pulse", bus.err, 1'b0);
    check1("len0_busy", bus.busy, 1'b0);
    tick();

    // Backpressure: toggling send_ready, rsink stalled for 5 cycles
    toggle_mode = 1'b1;
    write_xfer(4'd2, 16'h0100, 20'd4, 256'h3, 1'b1, 1'b0);
    read_xfer(4'd7, 16'h0200, 20'd3, -1, 5);
    toggle_mode = 1'b0;
    repeat (2) tick();

    // Bad write response and early recv_last during a read
    write_xfer(4'd9, 16'h0300, 20'd1, 256'h1, 1'b1, 1'b1);
    read_xfer(4'd4, 16'h0400, 20'd4, 1, 0);

    // Reset after 2 of 8 write flits, then a fresh read
    issue_cmd(1'b1, 4'd6, 16'h0080, 20'd8);
    push_wsrc(rnd256(), 1'b0);
    push_wsrc(rnd256(), 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    at_neg();
    check1("midrst_send_valid", bus.send_valid, 1'b0);
    check1("midrst_busy", bus.busy, 1'b0);
    check1("midrst_cmd_ready", bus.cmd_ready, 1'b1);
    check1("midrst_wsrc_ready", bus.wsrc_ready, 1'b0);
    tick();
    read_xfer(4'd2, 16'h0010, 20'd2, -1, 0);

    // Maximum length read: header encoding, bad config ack, no early last
    issue_cmd(1'b0, 4'hF, 16'hFFFF, 20'hFFFFF);
    d = rnd256();
    d[0] = 1'b0;
    send_recv(d, 1'b0, "cfg1_bad");
    at_neg();
    check1("cfg1_err", bus.err, 1'b1);
    tick();
    send_recv(rnd256(), 1'b0, "cfg2_long");
    for (int i = 0; i < 3; i++) begin
      d = rnd256();
      q_rsink.push_back({1'b0, d});
      send_recv(d, 1'b0, "long_beat");
      at_neg();
      check1("long_err", bus.err, 1'b0);
      check1("long_done", bus.done, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    at_neg();
    check1("long_rst_busy", bus.busy, 1'b0);
    tick();

    repeat (4) tick();
    checkw("send_queue_empty", 257'(q_send.size()), 257'(0));
    checkw("rsink_queue_empty", 257'(q_rsink.size()), 257'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
